// File: rtl/rkey_sched_ctrl.sv
// rkey_sched_ctrl: sequences the round-key shift ring (load, per-round shift, status).
// Optional zeroize path (key_clear port, ZERO state) is built when RKEY_ZEROIZE_EN is defined.
module rkey_sched_ctrl #(
  parameter int unsigned RKW = 128,
  parameter int unsigned CW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_start,
  input  logic [1:0]     key_nk,
  input  logic           rk_valid,
  input  logic [RKW-1:0] rk_data,
  output logic           rk_ready,
  input  logic           blk_start,
  input  logic           blk_inv,
  input  logic           round_adv,
`ifdef RKEY_ZEROIZE_EN
  input  logic           key_clear,
`endif
  output logic [1:0]     dist_nk,
  output logic           dist_load,
  output logic [RKW-1:0] dist_rk,
  output logic           dist_shift,
  output logic           dist_inv,
  output logic           key_ready,
  output logic           busy,
  output logic [CW-1:0]  round_idx,
  output logic           first_round,
  output logic           last_round,
  output logic           blk_done
);

`ifdef RKEY_ZEROIZE_EN
  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, ZERO} state_t;
  localparam logic [CW-1:0] ZERO_LAST = CW'(14);
`else
  typedef enum logic [1:0] {IDLE, LOAD, READY, RUN} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inv_q, inv_d;
  logic [1:0]    nk_d;
  logic [CW-1:0] idx_d;
  logic          shift_d, done_d;
  logic          key_ready_d, busy_d, first_d, last_d, dinv_d;

  // Last round number Nr for a key size; the schedule holds Nr+1 keys.
  function automatic logic [CW-1:0] nr_of(input logic [1:0] nk);
    case (nk)
      2'b00:   nr_of = CW'(10);
      2'b01:   nr_of = CW'(12);
      default: nr_of = CW'(14);
    endcase
  endfunction

  // Next-state, next-output and load-path logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    nk_d      = dist_nk;
    idx_d     = round_idx;
    shift_d   = 1'b0;
    done_d    = 1'b0;
    rk_ready  = 1'b0;
    dist_load = 1'b0;
    dist_rk   = '0;

    case (state_q)
      IDLE: begin
        if (key_start) begin
          state_d = LOAD;
          nk_d    = key_nk;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        rk_ready  = 1'b1;
        dist_rk   = rk_data;
        dist_load = rk_valid;
        if (rk_valid) begin
          if (cnt_q == nr_of(dist_nk)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      READY: begin
        if (key_start) begin
          state_d = LOAD;
          nk_d    = key_nk;
          cnt_d   = '0;
        end else if (blk_start) begin
          state_d = RUN;
          inv_d   = blk_inv;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (round_adv) begin
          shift_d = 1'b1;
          if (round_idx == nr_of(dist_nk)) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = READY;
          end else begin
            idx_d = round_idx + CW'(1);
          end
        end
      end
`ifdef RKEY_ZEROIZE_EN
      ZERO: begin
        dist_load = 1'b1;
        if (cnt_q == ZERO_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef RKEY_ZEROIZE_EN
    // key_clear overrides whatever the current state decided
    if (key_clear) begin
      state_d = ZERO;
      cnt_d   = '0;
      nk_d    = 2'b10;
      idx_d   = '0;
      inv_d   = 1'b0;
      shift_d = 1'b0;
      done_d  = 1'b0;
    end
`endif

    key_ready_d = (state_d == READY);
`ifdef RKEY_ZEROIZE_EN
    busy_d      = (state_d == LOAD) || (state_d == RUN) || (state_d == ZERO);
`else
    busy_d      = (state_d == LOAD) || (state_d == RUN);
`endif
    first_d     = (state_d == RUN) && (idx_d == '0);
    last_d      = (state_d == RUN) && (idx_d == nr_of(nk_d));
    // direction stays valid through the final shift, which lands after RUN exits
    dinv_d      = inv_d && ((state_d == RUN) || shift_d);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      dist_nk     <= 2'b00;
      dist_shift  <= 1'b0;
      dist_inv    <= 1'b0;
      key_ready   <= 1'b0;
      busy        <= 1'b0;
      round_idx   <= '0;
      first_round <= 1'b0;
      last_round  <= 1'b0;
      blk_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inv_q       <= inv_d;
      dist_nk     <= nk_d;
      dist_shift  <= shift_d;
      dist_inv    <= dinv_d;
      key_ready   <= key_ready_d;
      busy        <= busy_d;
      round_idx   <= idx_d;
      first_round <= first_d;
      last_round  <= last_d;
      blk_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_rkey_sched_ctrl.sv
// tb_rkey_sched_ctrl: randomized self-checking bench for rkey_sched_ctrl.
// Zeroize scenario is compiled in when RKEY_ZEROIZE_EN is defined.
module tb_rkey_sched_ctrl;
  localparam int unsigned RKW = 128;
  localparam int unsigned CW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           key_start, rk_valid, blk_start, blk_inv, round_adv;
  logic [1:0]     key_nk;
  logic [RKW-1:0] rk_data;
  logic           rk_ready, dist_load, dist_shift, dist_inv;
  logic [1:0]     dist_nk;
  logic [RKW-1:0] dist_rk;
  logic           key_ready, busy, first_round, last_round, blk_done;
  logic [CW-1:0]  round_idx;
`ifdef RKEY_ZEROIZE_EN
  logic           key_clear;
`endif

  int checks = 0;
  int errors = 0;
  int cur_nk = 0;

  rkey_sched_ctrl #(.RKW(RKW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_start(key_start), .key_nk(key_nk),
    .rk_valid(rk_valid), .rk_data(rk_data), .rk_ready(rk_ready),
    .blk_start(blk_start), .blk_inv(blk_inv), .round_adv(round_adv),
`ifdef RKEY_ZEROIZE_EN
    .key_clear(key_clear),
`endif
    .dist_nk(dist_nk), .dist_load(dist_load), .dist_rk(dist_rk),
    .dist_shift(dist_shift), .dist_inv(dist_inv),
    .key_ready(key_ready), .busy(busy), .round_idx(round_idx),
    .first_round(first_round), .last_round(last_round), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  // Reference rule: AES-128/192/256 use 10/12/14 rounds.
  function automatic int nr_of(input int nk);
    return (nk == 0) ? 10 : (nk == 1) ? 12 : 14;
  endfunction

  task automatic idle_inputs();
    key_start = 1'b0; blk_start = 1'b0; round_adv = 1'b0; rk_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    key_nk = 2'b11; blk_inv = 1'b1; rk_data = '1;
`ifdef RKEY_ZEROIZE_EN
    key_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rk_valid = 1'b1; round_adv = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0 || round_idx !== '0 || dist_nk !== 2'b00 ||
        dist_shift !== 1'b0 || dist_inv !== 1'b0 || first_round !== 1'b0 ||
        last_round !== 1'b0 || blk_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got kr=%0b busy=%0b idx=%0d nk=%0d sh=%0b inv=%0b fr=%0b lr=%0b dn=%0b, exp all 0",
               key_ready, busy, round_idx, dist_nk, dist_shift, dist_inv, first_round, last_round, blk_done);
    end
    checks++;
    if (rk_ready !== 1'b0 || dist_load !== 1'b0 || dist_rk !== '0) begin
      errors++;
      $display("FAIL reset_comb got rk_ready=%0b dist_load=%0b rk_nz=%0b, exp 0 0 0",
               rk_ready, dist_load, |dist_rk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0 || dist_shift !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%0b key_ready=%0b shift=%0b, exp 0 0 0",
               busy, key_ready, dist_shift);
    end
  endtask

  // Assumes LOAD was entered at the previous edge; streams keys with bubbles and noise.
  task automatic stream_keys(input int nk);
    int nkeys, got, cyc;
    nkeys = nr_of(nk) + 1;
    got = 0; cyc = 0;
    while (got < nkeys && cyc < 200) begin
      @(negedge clk);
      key_start = ($urandom_range(0, 4) == 0);
      key_nk    = 2'($urandom_range(0, 3));
      blk_start = ($urandom_range(0, 4) == 0);
      round_adv = ($urandom_range(0, 4) == 0);
      rk_valid  = (cyc != 2) && (cyc != 5) && (($urandom_range(0, 3) != 0) || cyc > 40);
      rk_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      checks++;
      if (rk_ready !== 1'b1 || dist_load !== rk_valid || dist_shift !== 1'b0 ||
          key_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL load_cycle%0d got rdy=%0b ld=%0b sh=%0b kr=%0b busy=%0b, exp 1 %0b 0 0 1",
                 cyc, rk_ready, dist_load, dist_shift, key_ready, busy, rk_valid);
      end
      if (rk_valid) begin
        checks++;
        if (dist_rk !== rk_data) begin
          errors++;
          $display("FAIL load_data key%0d got %h exp %h", got, dist_rk, rk_data);
        end
        got++;
      end
      cyc++;
    end
    checks++;
    if (got < nkeys) begin
      errors++;
      $display("FAIL load_timeout got %0d keys exp %0d", got, nkeys);
    end
    @(negedge clk);
    idle_inputs();
    rk_valid = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || rk_ready !== 1'b0 || dist_load !== 1'b0 ||
        dist_nk !== 2'(nk) || dist_shift !== 1'b0) begin
      errors++;
      $display("FAIL load_done got kr=%0b busy=%0b rdy=%0b ld=%0b nk=%0d sh=%0b, exp 1 0 0 0 %0d 0",
               key_ready, busy, rk_ready, dist_load, dist_nk, dist_shift, nk);
    end
    rk_valid = 1'b0;
    cur_nk = nk;
  endtask

  task automatic test_load(input int nk);
    @(negedge clk);
    idle_inputs();
    key_nk = 2'(nk);
    key_start = 1'b1;
    stream_keys(nk);
  endtask

  // One block from READY; round_adv every gap cycles, noise on ignored inputs.
  task automatic test_block(input logic inv, input int gap);
    int nr, r, cyc;
    logic prev_adv, done;
    nr = nr_of(cur_nk);
    @(negedge clk);
    idle_inputs();
    blk_start = 1'b1; blk_inv = inv;
    r = 0; cyc = 0; prev_adv = 1'b0; done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      blk_start = ($urandom_range(0, 4) == 0);
      blk_inv   = ~inv;
      key_start = ($urandom_range(0, 4) == 0);
      rk_valid  = ($urandom_range(0, 1) == 0);
      round_adv = ((cyc % gap) == gap - 1);
      #1;
      checks++;
      if (round_idx !== CW'(r) || first_round !== (r == 0) || last_round !== (r == nr) ||
          busy !== 1'b1 || key_ready !== 1'b0 || dist_shift !== prev_adv || blk_done !== 1'b0 ||
          dist_load !== 1'b0 || rk_ready !== 1'b0 || dist_inv !== inv) begin
        errors++;
        $display("FAIL run_cycle%0d got idx=%0d fr=%0b lr=%0b busy=%0b kr=%0b sh=%0b dn=%0b ld=%0b inv=%0b, exp idx=%0d fr=%0b lr=%0b sh=%0b inv=%0b",
                 cyc, round_idx, first_round, last_round, busy, key_ready, dist_shift, blk_done,
                 dist_load, dist_inv, r, (r == 0), (r == nr), prev_adv, inv);
      end
      prev_adv = round_adv;
      if (round_adv) begin
        if (r == nr) done = 1'b1;
        else r++;
      end
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_timeout got round %0d exp %0d", r, nr);
    end
    @(negedge clk);
    idle_inputs();
    round_adv = 1'b1;
    #1;
    checks++;
    if (dist_shift !== 1'b1 || blk_done !== 1'b1 || key_ready !== 1'b1 || busy !== 1'b0 ||
        round_idx !== '0 || first_round !== 1'b0 || last_round !== 1'b0 || dist_inv !== inv) begin
      errors++;
      $display("FAIL run_final got sh=%0b dn=%0b kr=%0b busy=%0b idx=%0d fr=%0b lr=%0b inv=%0b, exp 1 1 1 0 0 0 0 %0b",
               dist_shift, blk_done, key_ready, busy, round_idx, first_round, last_round, dist_inv, inv);
    end
    @(negedge clk);
    round_adv = 1'b0;
    #1;
    checks++;
    if (dist_shift !== 1'b0 || blk_done !== 1'b0 || key_ready !== 1'b1 || round_idx !== '0) begin
      errors++;
      $display("FAIL run_idle_adv got sh=%0b dn=%0b kr=%0b idx=%0d, exp 0 0 1 0",
               dist_shift, blk_done, key_ready, round_idx);
    end
  endtask

  task automatic test_coincident();
    @(negedge clk);
    idle_inputs();
    key_nk = 2'b00; key_start = 1'b1; blk_start = 1'b1; round_adv = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL coincide_pre got key_ready=%0b exp 1", key_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0 || rk_ready !== 1'b1 || dist_shift !== 1'b0 ||
        first_round !== 1'b0) begin
      errors++;
      $display("FAIL coincide got busy=%0b kr=%0b rdy=%0b sh=%0b fr=%0b, exp 1 0 1 0 0",
               busy, key_ready, rk_ready, dist_shift, first_round);
    end
    stream_keys(0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    idle_inputs();
    blk_start = 1'b1; blk_inv = 1'b1;
    repeat (5) begin
      @(negedge clk);
      blk_start = 1'b0; round_adv = 1'b1;
    end
    @(negedge clk);
    round_adv = 1'b0;
    #1;
    checks++;
    if (round_idx !== CW'(5) || dist_shift !== 1'b1 || dist_inv !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got idx=%0d sh=%0b inv=%0b, exp 5 1 1", round_idx, dist_shift, dist_inv);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || round_idx !== '0 || first_round !== 1'b0 || last_round !== 1'b0 ||
        key_ready !== 1'b0 || dist_nk !== 2'b00 || dist_inv !== 1'b0 || dist_shift !== 1'b0 ||
        blk_done !== 1'b0 || rk_ready !== 1'b0 || dist_load !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got busy=%0b idx=%0d fr=%0b lr=%0b kr=%0b nk=%0d inv=%0b sh=%0b dn=%0b rdy=%0b ld=%0b, exp all 0",
               busy, round_idx, first_round, last_round, key_ready, dist_nk, dist_inv,
               dist_shift, blk_done, rk_ready, dist_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      blk_start = 1'b1; round_adv = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || first_round !== 1'b0 || dist_shift !== 1'b0 || key_ready !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_blk%0d got busy=%0b fr=%0b sh=%0b kr=%0b, exp 0 0 0 0",
                 i, busy, first_round, dist_shift, key_ready);
      end
    end
    idle_inputs();
  endtask

`ifdef RKEY_ZEROIZE_EN
  task automatic test_zeroize();
    @(negedge clk);
    idle_inputs();
    blk_start = 1'b1; blk_inv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      blk_start = 1'b0; round_adv = 1'b1;
    end
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0; round_adv = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      rk_valid = ($urandom_range(0, 1) == 0);
      rk_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      checks++;
      if (dist_load !== 1'b1 || dist_rk !== '0 || rk_ready !== 1'b0 || busy !== 1'b1 ||
          dist_nk !== 2'b10 || dist_shift !== 1'b0 || key_ready !== 1'b0) begin
        errors++;
        $display("FAIL zero_cycle%0d got ld=%0b rk_nz=%0b rdy=%0b busy=%0b nk=%0d sh=%0b kr=%0b, exp 1 0 0 1 2 0 0",
                 i, dist_load, |dist_rk, rk_ready, busy, dist_nk, dist_shift, key_ready);
      end
    end
    @(negedge clk);
    rk_valid = 1'b0; blk_start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dist_load !== 1'b0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_exit got busy=%0b ld=%0b kr=%0b, exp 0 0 0", busy, dist_load, key_ready);
    end
    @(negedge clk);
    blk_start = 1'b0;
    #1;
    checks++;
    if (first_round !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_blk_ignored got fr=%0b busy=%0b, exp 0 0", first_round, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load(0);
    test_block(1'b0, 1);
    test_load(2);
    test_block(1'b0, 1);
    test_load(1);
    test_block(1'b1, 3);
    test_coincident();
    test_block(1'b1, 2);
    test_load(2);
    test_reset_mid_run();
    test_load(0);
    test_block(1'b1, 1);
    for (int k = 0; k < 3; k++) begin
      test_load(int'($urandom_range(0, 3)));
      test_block(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
    end
`ifdef RKEY_ZEROIZE_EN
    test_load(1);
    test_zeroize();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
